// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Runs WIDTH shift-add / restoring-divide iterations and owns the HI/LO registers.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_ex,
    input  logic [1:0]       op_ex,
    input  logic [WIDTH-1:0] opa_ex,
    input  logic [WIDTH-1:0] opb_ex,
    input  logic             flush,
    output logic             stall_ex,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opaRaw;
    logic [WIDTH-1:0]   r_opb;
    logic               r_signQ;
    logic               r_signR;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divZero;

    logic               w_accept;
    logic               w_commit;
    logic               w_signA;
    logic               w_signB;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divTrial;
    logic [2*WIDTH-1:0] w_accNext;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_hiNext;
    logic [WIDTH-1:0]   w_loNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // done blocks re-acceptance so the instruction leaving EX on the done cycle is not restarted.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_ex && !r_done && !flush) begin
                    w_accept    = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    w_nextState = IDLE;
                end else if (r_cnt == CW'(WIDTH - 1)) begin
                    w_nextState = FIX;
                end
            end
            FIX: begin
                w_nextState = IDLE;
                w_commit    = !flush;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        stall_ex = (r_state != IDLE) || w_accept;
    end

    // op bit 0 marks the signed variants; the negated 0x80000000 stays 0x80000000 as an unsigned magnitude.
    always_comb begin
        w_signA = op_ex[0] & opa_ex[WIDTH-1];
        w_signB = op_ex[0] & opb_ex[WIDTH-1];
        w_magA  = w_signA ? -opa_ex : opa_ex;
        w_magB  = w_signB ? -opb_ex : opb_ex;
    end

    // The accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
        w_divShift = r_acc[2*WIDTH-1:WIDTH-1];
        w_divTrial = w_divShift - {1'b0, r_opb};
        w_accNext  = r_acc;
        if (r_op[1]) begin
            if (!w_divTrial[WIDTH]) begin
                w_accNext = {w_divTrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_accNext = {w_divShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                w_accNext = {w_mulSum, r_acc[WIDTH-1:1]};
            end else begin
                w_accNext = {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up; unsigned ops never set the sign flags, so they pass through unchanged.
    always_comb begin
        w_product = r_signQ ? -r_acc : r_acc;
        w_hiNext  = w_product[2*WIDTH-1:WIDTH];
        w_loNext  = w_product[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_opb == '0) begin
                w_hiNext = r_opaRaw;
                w_loNext = '1;
            end else begin
                w_loNext = r_signQ ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_hiNext = r_signR ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= 2'b00;
            r_opaRaw  <= '0;
            r_opb     <= '0;
            r_signQ   <= 1'b0;
            r_signR   <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_op      <= op_ex;
                r_opaRaw  <= opa_ex;
                r_opb     <= w_magB;
                r_signQ   <= w_signA ^ w_signB;
                r_signR   <= w_signA;
                r_cnt     <= '0;
                r_acc     <= {{WIDTH{1'b0}}, w_magA};
                r_divZero <= 1'b0;
            end else if (r_state == BUSY) begin
                r_acc <= w_accNext;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_commit) begin
                r_hi      <= w_hiNext;
                r_lo      <= w_loNext;
                r_divZero <= r_op[1] && (r_opb == '0);
            end
        end
    end

    assign done     = r_done;
    assign div_zero = r_divZero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes model results, a monitor checks each done pulse.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start_ex;
    logic [1:0]  op_ex;
    logic [31:0] opa_ex;
    logic [31:0] opb_ex;
    logic        flush;
    logic        stall_ex;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        scoreQ[$];
    int          testCount = 0;
    int          failCount = 0;
    logic [31:0] expHi = 32'h0;
    logic [31:0] expLo = 32'h0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_ex (start_ex),
        .op_ex    (op_ex),
        .opa_ex   (opa_ex),
        .opb_ex   (opb_ex),
        .flush    (flush),
        .stall_ex (stall_ex),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference results from plain integer arithmetic: {div_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: begin
                p = 64'(a) * 64'(b);
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                if (op == 2'b10) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        exp_t        e;
        int          cycles;
        @(negedge clk);
        start_ex = 1'b1;
        op_ex    = op;
        opa_ex   = a;
        opb_ex   = b;
        m        = model(op, a, b);
        e.hi     = m[63:32];
        e.lo     = m[31:0];
        e.dz     = m[64];
        scoreQ.push_back(e);
        expHi    = e.hi;
        expLo    = e.lo;
        #1;
        cycles = 0;
        while (stall_ex && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
            if (cycles == 1) checkOutput("div_zero cleared at accept", 64'(div_zero), 64'd0);
        end
        checkOutput("stall cycles", 64'(cycles), 64'd34);
        checkOutput("done pulse after stall", 64'(done), 64'd1);
        start_ex = 1'b0;
    endtask

    // Start a divide, squash it in cycle flushAt, and confirm HI/LO are untouched.
    task automatic applyFlush(input logic [31:0] a, input logic [31:0] b, input int flushAt);
        @(negedge clk);
        start_ex = 1'b1;
        op_ex    = 2'b11;
        opa_ex   = a;
        opb_ex   = b;
        repeat (flushAt) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        start_ex = 1'b0;
        #1;
        checkOutput("stall after flush", 64'(stall_ex), 64'd0);
        checkOutput("done after flush", 64'(done), 64'd0);
        checkOutput("hi kept after flush", 64'(hi), 64'(expHi));
        checkOutput("lo kept after flush", 64'(lo), 64'(expLo));
        repeat (3) @(negedge clk);
        #1;
        checkOutput("still idle after flush", 64'(stall_ex), 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpected done", 64'(done), 64'd0);
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("hi", 64'(hi), 64'(e.hi));
                    checkOutput("lo", 64'(lo), 64'(e.lo));
                    checkOutput("div_zero", 64'(div_zero), 64'(e.dz));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start_ex = 1'b0;
        op_ex    = 2'b00;
        opa_ex   = 32'h0;
        opb_ex   = 32'h0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset div_zero", 64'(div_zero), 64'd0);
        checkOutput("reset stall", 64'(stall_ex), 64'd0);
        rst = 1'b0;

        applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(2'b01, 32'hFFFFFFFD, 32'h00000005);
        applyStimulus(2'b01, 32'h80000000, 32'h80000000);
        applyStimulus(2'b11, 32'hFFFFFFF9, 32'h00000002);
        applyStimulus(2'b10, 32'd100, 32'd7);
        applyStimulus(2'b10, 32'h00000064, 32'h0);
        applyStimulus(2'b00, 32'd2, 32'd3);

        applyStimulus(2'b00, 32'd1, 32'd1);
        applyFlush(32'h12345678, 32'd3, 10);
        applyFlush(32'h12345678, 32'd3, 33);

        @(negedge clk);
        start_ex = 1'b1;
        op_ex    = 2'b10;
        opa_ex   = 32'd1000;
        opb_ex   = 32'd9;
        repeat (20) @(negedge clk);
        #2;
        rst      = 1'b1;
        start_ex = 1'b0;
        #1;
        checkOutput("async reset hi", 64'(hi), 64'd0);
        checkOutput("async reset lo", 64'(lo), 64'd0);
        checkOutput("async reset stall", 64'(stall_ex), 64'd0);
        checkOutput("async reset done", 64'(done), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        expHi = 32'h0;
        expLo = 32'h0;
        applyStimulus(2'b00, 32'd4, 32'd5);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand());
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 64'(scoreQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
